// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for the shared async SRAM; video has priority, host starvation bounded by MAX_VIDEO_RUN.
// Ack one cycle after grant; read data valid ACCESS_CYCLES+1 after grant; requesters hold req until ack.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_VIDEO_RUN = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        vid_req,
  input  logic [17:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_rdata,
  output logic        vid_rvalid,

  input  logic        host_req,
  input  logic        host_we,
  input  logic [17:0] host_addr,
  input  logic [15:0] host_wdata,
  input  logic [1:0]  host_be,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,

  output logic [17:0] ram_addr,
  input  logic [15:0] ram_din,
  output logic [15:0] ram_dout,
  output logic        ram_ce,
  output logic        ram_oe,
  output logic        ram_we,
  output logic        ram_lb,
  output logic        ram_hb
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int RW = $clog2(MAX_VIDEO_RUN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_VIDEO_RUN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] run_cnt, run_nxt;
  logic          cnt_last;
  logic          grant_vid, grant_host;

  // Captured request attributes for the access in flight.
  logic          owner_vid;
  logic [1:0]    cap_be;
  logic [15:0]   cap_wdata;

  logic [17:0]   addr_nxt;
  logic [1:0]    be_sel;
  logic [15:0]   wdata_sel, dout_nxt;
  logic          ce_nxt, oe_nxt, we_nxt, lb_nxt, hb_nxt, write_nxt;
  logic          read_done;

  assign cnt_last  = (cnt == CNT_LAST);
  assign read_done = (state == S_READ) && cnt_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      run_cnt <= run_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    run_nxt    = run_cnt;
    grant_vid  = 1'b0;
    grant_host = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (vid_req && !((run_cnt == RUN_MAX) && host_req)) begin
          grant_vid = 1'b1;
          state_nxt = S_READ;
          if (run_cnt != RUN_MAX) run_nxt = run_cnt + 1'b1;
        end else if (host_req) begin
          grant_host = 1'b1;
          state_nxt  = host_we ? S_W_SETUP : S_READ;
          run_nxt    = '0;
        end else begin
          run_nxt = '0;
        end
      end
      S_READ: begin
        if (cnt_last) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_W_SETUP: begin
        state_nxt = S_W_PULSE;
        cnt_nxt   = '0;
      end
      S_W_PULSE: begin
        if (cnt_last) begin
          state_nxt = S_W_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_W_HOLD: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered SRAM bus, derived from the state being entered.
  always_comb begin
    addr_nxt  = ram_addr;
    be_sel    = cap_be;
    wdata_sel = cap_wdata;
    if (grant_vid) begin
      addr_nxt = vid_addr;
    end else if (grant_host) begin
      addr_nxt  = host_addr;
      be_sel    = host_be;
      wdata_sel = host_wdata;
    end
    ce_nxt    = (state_nxt != S_IDLE);
    oe_nxt    = (state_nxt == S_READ);
    we_nxt    = (state_nxt == S_W_PULSE);
    write_nxt = (state_nxt == S_W_SETUP) || (state_nxt == S_W_PULSE) ||
                (state_nxt == S_W_HOLD);
    lb_nxt    = oe_nxt || (write_nxt && be_sel[0]);
    hb_nxt    = oe_nxt || (write_nxt && be_sel[1]);
    dout_nxt  = write_nxt ? wdata_sel : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_vid   <= 1'b0;
      cap_be      <= 2'b00;
      cap_wdata   <= 16'h0000;
      ram_addr    <= 18'h00000;
      ram_dout    <= 16'h0000;
      ram_ce      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_we      <= 1'b0;
      ram_lb      <= 1'b0;
      ram_hb      <= 1'b0;
      vid_ack     <= 1'b0;
      host_ack    <= 1'b0;
      vid_rdata   <= 16'h0000;
      host_rdata  <= 16'h0000;
      vid_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      if (grant_vid) begin
        owner_vid <= 1'b1;
      end else if (grant_host) begin
        owner_vid <= 1'b0;
        cap_be    <= host_be;
        cap_wdata <= host_wdata;
      end
      ram_addr    <= addr_nxt;
      ram_dout    <= dout_nxt;
      ram_ce      <= ce_nxt;
      ram_oe      <= oe_nxt;
      ram_we      <= we_nxt;
      ram_lb      <= lb_nxt;
      ram_hb      <= hb_nxt;
      vid_ack     <= grant_vid;
      host_ack    <= grant_host;
      vid_rvalid  <= read_done && owner_vid;
      host_rvalid <= read_done && !owner_vid;
      if (read_done && owner_vid)  vid_rdata  <= ram_din;
      if (read_done && !owner_vid) host_rdata <= ram_din;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with default parameters (ACCESS_CYCLES=2, MAX_VIDEO_RUN=8).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [17:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        vid_rvalid;
  logic        host_req;
  logic        host_we;
  logic [17:0] host_addr;
  logic [15:0] host_wdata;
  logic [1:0]  host_be;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic [17:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_be(host_be), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
    .ram_lb(ram_lb), .ram_hb(ram_hb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_grants, rv_host, last_we, first_oe, ack_cnt, we_cnt, ce_cnt, oe_cnt;
    logic prev_we;

    reset = 1'b1; vid_req = 1'b0; vid_addr = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; host_be = 2'b00; ram_din = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ce",    32'(ram_ce), 0);
    check("rst_oe",    32'(ram_oe), 0);
    check("rst_we",    32'(ram_we), 0);
    check("rst_addr",  32'(ram_addr), 0);
    check("rst_dout",  32'(ram_dout), 0);
    check("rst_acks",  32'({vid_ack, host_ack, vid_rvalid, host_rvalid}), 0);
    check("rst_rdata", 32'({vid_rdata, host_rdata}), 0);

    // Video read of 0x00123 returning 0xBEEF.
    vid_req = 1'b1; vid_addr = 18'h00123; ram_din = 16'hBEEF;
    tick();
    vid_req = 1'b0; vid_addr = 18'h0;
    check("v1_ack",   32'(vid_ack), 1);
    check("v1_oe1",   32'(ram_oe), 1);
    check("v1_addr",  32'(ram_addr), 32'h00123);
    check("v1_lbhb",  32'({ram_lb, ram_hb, ram_ce, ram_we}), 32'b1110);
    check("v1_hack",  32'(host_ack), 0);
    tick();
    check("v1_oe2",   32'(ram_oe), 1);
    check("v1_ack2",  32'(vid_ack), 0);
    check("v1_rv_early", 32'(vid_rvalid), 0);
    tick();
    check("v1_oe3",   32'(ram_oe), 0);
    check("v1_rvalid", 32'(vid_rvalid), 1);
    check("v1_rdata", 32'(vid_rdata), 32'hBEEF);
    check("v1_host_out", 32'({host_rvalid, host_rdata}), 0);
    tick();
    check("v1_rvalid_pulse", 32'(vid_rvalid), 0);

    // Host write 0x3FFFF <- 0xA55A, be=10; inputs scrambled after ack.
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h3FFFF; host_wdata = 16'hA55A; host_be = 2'b10;
    tick();
    check("w1_ack", 32'(host_ack), 1);
    host_req = 1'b0; host_addr = 18'h0; host_wdata = 16'h0; host_be = 2'b11;
    we_cnt = 0; ce_cnt = ram_ce ? 1 : 0; oe_cnt = ram_oe ? 1 : 0; rv_host = 0;
    check("w1_setup_we", 32'(ram_we), 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ram_we) begin
        we_cnt++;
        check("w1_pulse_lbhb", 32'({ram_lb, ram_hb}), 32'b01);
        check("w1_pulse_dout", 32'(ram_dout), 32'hA55A);
      end
      if (ram_ce) begin
        ce_cnt++;
        check("w1_addr", 32'(ram_addr), 32'h3FFFF);
      end
      if (ram_oe) oe_cnt++;
      if (host_rvalid) rv_host++;
    end
    check("w1_we_cycles", 32'(we_cnt), 2);
    check("w1_ce_cycles", 32'(ce_cnt), 4);
    check("w1_oe_cycles", 32'(oe_cnt), 0);
    check("w1_no_rvalid", 32'(rv_host), 0);

    // Continuous contention: 8 video grants, then 1 host read, repeating.
    vid_req = 1'b1; vid_addr = 18'h00200; host_req = 1'b1; host_we = 1'b0;
    host_addr = 18'h00300; host_be = 2'b11; ram_din = 16'h5A5A;
    n_grants = 0; rv_host = 0;
    for (int c = 0; c < 200 && n_grants < 18; c++) begin
      tick();
      check("arb_one_ack", 32'(vid_ack & host_ack), 0);
      if (vid_ack || host_ack) begin
        check($sformatf("arb_grant%0d", n_grants), 32'(host_ack),
              (n_grants == 8 || n_grants == 17) ? 32'd1 : 32'd0);
        n_grants++;
      end
      if (host_rvalid) rv_host++;
    end
    vid_req = 1'b0; host_req = 1'b0;
    check("arb_grant_count", 32'(n_grants), 18);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (host_rvalid) rv_host++;
    end
    check("arb_host_rvalids", 32'(rv_host), 2);
    check("arb_host_rdata", 32'(host_rdata), 32'h5A5A);

    // Host write immediately followed by a video read: turnaround gap.
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00010; host_wdata = 16'h1234; host_be = 2'b11;
    ram_din = 16'h0F0F;
    tick();
    check("ta_wack", 32'(host_ack), 1);
    host_req = 1'b0; vid_req = 1'b1; vid_addr = 18'h00020;
    last_we = -1; first_oe = -1; prev_we = ram_we;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (vid_ack) vid_req = 1'b0;
      if (ram_we) last_we = c;
      if (ram_oe && first_oe < 0) first_oe = c;
      check("ta_oe_we_overlap", 32'(ram_oe & ram_we), 0);
      check("ta_oe_after_we", 32'(ram_oe & prev_we), 0);
      if (ram_oe) check("ta_dout_in_read", 32'(ram_dout), 0);
      prev_we = ram_we;
    end
    check("ta_read_seen", 32'(first_oe > 0), 1);
    check("ta_gap", 32'((first_oe - last_we) >= 2), 1);
    check("ta_vid_rdata", 32'(vid_rdata), 32'h0F0F);

    // Host read with be=00 still fetches both bytes.
    host_req = 1'b1; host_we = 1'b0; host_addr = 18'h00077; host_be = 2'b00; ram_din = 16'hFFFF;
    tick();
    check("be0_ack", 32'(host_ack), 1);
    check("be0_lbhb", 32'({ram_lb, ram_hb, ram_oe}), 32'b111);
    host_req = 1'b0;
    tick(); tick();
    check("be0_rvalid", 32'(host_rvalid), 1);
    check("be0_rdata", 32'(host_rdata), 32'hFFFF);
    check("be0_vid_rdata", 32'(vid_rdata), 32'h0F0F);
    check("be0_vid_rvalid", 32'(vid_rvalid), 0);
    tick();

    // Reset during W_PULSE aborts the write.
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00055; host_wdata = 16'hCAFE; host_be = 2'b01;
    tick();
    tick();
    check("rp_we_before", 32'(ram_we), 1);
    reset = 1'b1; host_req = 1'b0;
    tick();
    reset = 1'b0;
    check("rp_we",    32'(ram_we), 0);
    check("rp_ce",    32'(ram_ce), 0);
    check("rp_acks",  32'({vid_ack, host_ack}), 0);
    check("rp_dout",  32'(ram_dout), 0);
    check("rp_vid_rdata", 32'(vid_rdata), 0);
    ack_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (host_ack || host_rvalid || ram_we) ack_cnt++;
    end
    check("rp_no_reissue", 32'(ack_cnt), 0);
    host_req = 1'b1; host_we = 1'b0; host_addr = 18'h00066; host_be = 2'b11; ram_din = 16'h1111;
    tick();
    check("rp_new_ack", 32'(host_ack), 1);
    host_req = 1'b0;
    tick(); tick();
    check("rp_new_rvalid", 32'(host_rvalid), 1);
    check("rp_new_rdata", 32'(host_rdata), 32'h1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
